bcd_countdown: RTL and testbench
================================

# bcd_countdown

Two-digit BCD countdown timer that consumes the slow divided clock from the frequency divider and produces the value shown on the display digits. It turns each rising edge of the slow clock into a single-cycle tick in the `clk` domain, and decrements on that tick while running. It has a start/pause/load control FSM and terminal-count detection. It sits between the frequency divider (upstream) and the 7-segment/BCD display driver (downstream).

## Interface
- `INIT_TENS`, default 3: tens digit loaded at reset and on `load`. Legal range 0–9.
- `INIT_ONES`, default 0: ones digit loaded at reset and on `load`. Legal range 0–9.

- `clk`  in  1  system clock. All logic runs on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `slow_clk`  in  1  divided clock from the frequency divider. It is generated from `clk`, so it is synchronous to `clk` and needs no synchronizer.
- `start_pause`  in  1  single-cycle, already-debounced pulse that toggles run/pause.
- `load`  in  1  single-cycle pulse that reloads the INIT value and returns to IDLE.
- `tens`  out  4  BCD tens digit, registered.
- `ones`  out  4  BCD ones digit, registered.
- `running`  out  1  high while in RUN, registered.
- `done`  out  1  high while in DONE, registered.

## Operation
- **Tick generation:** register `slow_q` samples `slow_clk` every cycle.
  - `tick = slow_clk & ~slow_q`.
  - Exactly one `tick` per `slow_clk` rising edge.
- **FSM states:** IDLE, RUN, PAUSE, DONE.
- **Priority within a cycle:** `load` > `start_pause` > `tick`.
- **`load` (any state):** next state IDLE; `tens`/`ones` become INIT_TENS/INIT_ONES. Any `start_pause` or `tick` in the same cycle is ignored.
- **IDLE:**
  - `start_pause` → RUN, or → DONE directly if the current value is 00.
  - `tick` is ignored.
- **RUN:**
  - `tick` decrements the value.
  - A decrement that reaches 00 → DONE in the same update.
  - `start_pause` → PAUSE.
  - If `start_pause` and `tick` arrive together, the tick is still applied, then the FSM enters PAUSE. If that decrement reaches 00, the FSM enters DONE instead.
- **PAUSE:**
  - `start_pause` → RUN.
  - `tick` is ignored, so the value is frozen.
- **DONE:**
  - Value is held at 00.
  - `start_pause` and `tick` are ignored.
  - Only `load` or reset leaves DONE.
- **BCD decrement rule:**
  - If `ones` ≠ 0: `ones` − 1.
  - Otherwise: `ones` = 9 and `tens` − 1.
  - The value never wraps below 00 (guaranteed by the DONE transition).
  - Digits are always in the range 0–9.

## Timing
- **Reset values (asynchronous):**
  - `tens` = INIT_TENS, `ones` = INIT_ONES.
  - State IDLE, `slow_q` = 0, `running` = 0, `done` = 0.
- **Tick latency:** the count register updates at the first `clk` edge that samples `slow_clk` = 1 with `slow_q` = 0. The new value is visible 1 cycle after `slow_clk` is first seen high.
- **Control latency:** state, `running` and `done` update at the same edge that samples `start_pause` or `load`. There is no extra latency.
- **`slow_clk` already high at reset release:** `slow_q` = 0 after reset, so a tick fires on the first edge. This is acceptable because the FSM is in IDLE, where ticks are ignored.
- **Reset mid-count:** immediate asynchronous return to IDLE with the INIT value. No partial state is retained.
- **`slow_clk` period:** must be at least 2 `clk` cycles; ticks are then never merged or lost.

## Structure
- Shared package `timer_pkg`:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3;
  - `BCD_W` = 4.
- Sub-module `rise_detect` (`clk`, `rst_n`, `in`, `pulse`): the `slow_q` register plus the AND gate. It is reused later for button one-pulse logic.
- Top level:
  - FSM: next-state logic combinational, state register sequential.
  - Digit next-value logic combinational; digit registers sequential.
  - Output registers.

## Test plan
- **Reset, then free count:**
  - Stimulus: default params; pulse `start_pause`, then 3 `slow_clk` rising edges.
  - Required response: `running` = 1; digits 29, 28, 27, each changing 1 cycle after the edge is seen.
- **Borrow across tens:**
  - Stimulus: INIT=10, start, 1 tick.
  - Required response: tens = 0, ones = 9.
- **Terminal count:**
  - Stimulus: INIT=02, start, 2 ticks.
  - Required response: value 00, `done` = 1 and `running` = 0 at the same edge.
  - Follow-up stimulus: further ticks and `start_pause` pulses.
  - Required response: value stays 00 and `done` stays 1.
- **Pause/resume:**
  - Stimulus: from 27, pulse `start_pause` coincident with a tick.
  - Required response: value 26, state PAUSE.
  - Follow-up stimulus: 5 more ticks.
  - Required response: value still 26.
  - Follow-up stimulus: `start_pause`, then 1 tick.
  - Required response: value 25.
- **Load priority:**
  - Stimulus: in RUN at 15, assert `load`, `start_pause` and `tick` in the same cycle.
  - Required response: value 30, IDLE, `running` = 0, `done` = 0.
  - Stimulus: from DONE, `load`.
  - Required response: value 30, `done` = 0.
- **Asynchronous reset mid-run:**
  - Stimulus: at value 22, drop `rst_n` between `clk` edges.
  - Required response: outputs immediately 30/IDLE.
  - Follow-up stimulus: hold `slow_clk` high through reset release.
  - Required response: the spurious first tick causes no decrement.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: digit width, FSM state
// encoding and the two-digit BCD decrement.
package timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Borrow from tens when ones is already zero; callers never pass 00.
    function automatic logic [2*BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] t,
                                                   input logic [BCD_W-1:0] o);
        if (o != '0) begin
            return {t, o - 4'd1};
        end
        return {t - 4'd1, 4'd9};
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on each rising edge of a clk-synchronous input.
// Also intended for the button one-pulse logic.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic in_d;
    logic in_q;

    always_comb begin
        in_d = in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown timer with a start/pause/load FSM, driven by
// ticks derived from the divided slow clock.
module bcd_countdown #(
    parameter int INIT_TENS = 3,
    parameter int INIT_ONES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       slow_clk,
    input  logic       start_pause,
    input  logic       load,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       done
);

    import timer_pkg::*;

    localparam logic [BCD_W-1:0] INIT_T = INIT_TENS[BCD_W-1:0];
    localparam logic [BCD_W-1:0] INIT_O = INIT_ONES[BCD_W-1:0];

    logic             tick;
    state_t           state_d, state_q;
    logic [BCD_W-1:0] tens_d, tens_q;
    logic [BCD_W-1:0] ones_d, ones_q;
    logic             running_d, running_q;
    logic             done_d, done_q;
    logic [BCD_W-1:0] dec_tens, dec_ones;
    logic             dec_zero;

    rise_detect u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (slow_clk),
        .pulse (tick)
    );

    // load beats start_pause beats tick; a tick that lands on zero wins over pause.
    always_comb begin
        state_d            = state_q;
        tens_d             = tens_q;
        ones_d             = ones_q;
        {dec_tens, dec_ones} = bcd_dec(tens_q, ones_q);
        dec_zero           = (dec_tens == '0) && (dec_ones == '0);

        if (load) begin
            state_d = IDLE;
            tens_d  = INIT_T;
            ones_d  = INIT_O;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_pause) begin
                        state_d = ((tens_q == '0) && (ones_q == '0)) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        tens_d = dec_tens;
                        ones_d = dec_ones;
                        if (dec_zero) begin
                            state_d = DONE;
                        end else if (start_pause) begin
                            state_d = PAUSE;
                        end
                    end else if (start_pause) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    tens_d = '0;
                    ones_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tens_q    <= INIT_T;
            ones_q    <= INIT_O;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Self-checking bench for bcd_countdown: directed scenarios plus a random
// run, all compared against a decimal-count reference model.
module tb_bcd_countdown;

    logic       clk;
    logic       rst_n;
    logic       slow_clk;
    logic       start_pause;
    logic       load;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       done;

    int total;
    int bad;

    // Reference model: count held as a plain integer, mode as a bench-local enum.
    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
    int    m_val;
    mode_t m_mode;
    logic  m_prev;

    bcd_countdown dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slow_clk    (slow_clk),
        .start_pause (start_pause),
        .load        (load),
        .tens        (tens),
        .ones        (ones),
        .running     (running),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] exp_vec();
        return {4'(m_val / 10), 4'(m_val % 10), m_mode == M_RUN, m_mode == M_DONE};
    endfunction

    function automatic logic [9:0] act_vec();
        return {tens, ones, running, done};
    endfunction

    task automatic model_reset();
        m_val  = 30;
        m_mode = M_IDLE;
        m_prev = 1'b0;
    endtask

    task automatic model_update(input logic ld, input logic sp, input logic sc);
        logic tk;
        tk     = sc && !m_prev;
        m_prev = sc;
        if (ld) begin
            m_val  = 30;
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE:  if (sp) m_mode = (m_val == 0) ? M_DONE : M_RUN;
                M_RUN: begin
                    if (tk) begin
                        m_val = m_val - 1;
                        if (m_val == 0) m_mode = M_DONE;
                        else if (sp)    m_mode = M_PAUSE;
                    end else if (sp) begin
                        m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (sp) m_mode = M_RUN;
                default: ;
            endcase
        end
    endtask

    // Drive inputs at the falling edge, let the model follow the rising edge,
    // and leave the caller 1 time unit after that edge to sample outputs.
    task automatic step(input logic ld, input logic sp, input logic sc);
        @(negedge clk);
        load        = ld;
        start_pause = sp;
        slow_clk    = sc;
        @(posedge clk);
        model_update(ld, sp, sc);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; start_pause = 1'b0; slow_clk = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (act_vec() !== 10'b0011_0000_00) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h want %h", act_vec(), 10'b0011_0000_00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_free_count();
        step(0, 1, 0);
        total++;
        if (running !== 1'b1 || act_vec() !== exp_vec()) begin
            bad++;
            $display("[TB] FAIL start_run: got %h want %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            step(0, 0, 1);
            total++;
            if (act_vec() !== exp_vec() || m_val != 29 - i) begin
                bad++;
                $display("[TB] FAIL free_count_%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        step(0, 0, 0);
    endtask

    task automatic test_pause_resume();
        step(0, 1, 1);
        total++;
        if (act_vec() !== exp_vec() || m_mode != M_PAUSE || m_val != 26) begin
            bad++;
            $display("[TB] FAIL pause_with_tick: got %h want %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            step(0, 0, 1);
        end
        total++;
        if (act_vec() !== {4'd2, 4'd6, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL pause_frozen: got %h want %h", act_vec(), {4'd2, 4'd6, 2'b00});
        end
        step(0, 1, 0);
        step(0, 0, 1);
        total++;
        if (act_vec() !== exp_vec() || m_val != 25) begin
            bad++;
            $display("[TB] FAIL resume_tick: got %h want %h", act_vec(), exp_vec());
        end
        step(0, 0, 0);
    endtask

    task automatic test_borrow();
        while (m_val > 10) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        step(0, 0, 1);
        total++;
        if (tens !== 4'd0 || ones !== 4'd9 || act_vec() !== exp_vec()) begin
            bad++;
            $display("[TB] FAIL borrow_10_to_09: got %h want %h", act_vec(), exp_vec());
        end
        step(0, 0, 0);
    endtask

    task automatic test_terminal();
        while (m_val > 1) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        step(0, 0, 1);
        total++;
        if (act_vec() !== {8'h00, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL terminal_count: got %h want %h", act_vec(), {8'h00, 2'b01});
        end
        for (int i = 0; i < 6; i++) begin
            step(0, i[0], 0);
            step(0, i[1], 1);
            total++;
            if (act_vec() !== {8'h00, 1'b0, 1'b1}) begin
                bad++;
                $display("[TB] FAIL done_hold_%0d: got %h want %h", i, act_vec(), {8'h00, 2'b01});
            end
        end
        step(0, 0, 0);
    endtask

    task automatic test_load_priority();
        step(1, 0, 0);
        total++;
        if (act_vec() !== {4'd3, 4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL load_from_done: got %h want %h", act_vec(), {4'd3, 4'd0, 2'b00});
        end
        step(0, 1, 0);
        while (m_val > 15) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        step(1, 1, 1);
        total++;
        if (act_vec() !== {4'd3, 4'd0, 1'b0, 1'b0} || act_vec() !== exp_vec()) begin
            bad++;
            $display("[TB] FAIL load_priority: got %h want %h", act_vec(), {4'd3, 4'd0, 2'b00});
        end
        step(0, 0, 0);
    endtask

    task automatic test_async_reset();
        step(0, 1, 0);
        while (m_val > 22) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (act_vec() !== {4'd3, 4'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL async_reset: got %h want %h", act_vec(), {4'd3, 4'd0, 2'b00});
        end
        model_reset();
        load = 1'b0; start_pause = 1'b0; slow_clk = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1);
        total++;
        if (act_vec() !== exp_vec() || m_val != 30) begin
            bad++;
            $display("[TB] FAIL spurious_tick_idle: got %h want %h", act_vec(), exp_vec());
        end
        step(0, 1, 1);
        step(0, 0, 1);
        total++;
        if (act_vec() !== {4'd3, 4'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL held_high_no_tick: got %h want %h", act_vec(), {4'd3, 4'd0, 2'b10});
        end
        step(0, 0, 0);
        step(0, 0, 1);
        total++;
        if (act_vec() !== exp_vec() || m_val != 29) begin
            bad++;
            $display("[TB] FAIL first_real_tick: got %h want %h", act_vec(), exp_vec());
        end
        step(0, 0, 0);
    endtask

    // Random controls with slow_clk held 1..3 cycles per level, so its
    // period never drops below 2 clk cycles.
    task automatic test_random();
        logic sc;
        int   hold;
        sc   = 1'b0;
        hold = 1;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                sc   = ~sc;
                hold = $urandom_range(1, 3);
            end
            hold--;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0), sc);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("[TB] FAIL random_%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_free_count();
        test_pause_resume();
        test_borrow();
        test_terminal();
        test_load_priority();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
